// File: rtl/out_port_serial_pkg.sv
// Shared definitions for the SAP-II serial output port: FSM state encodings,
// serial line levels and a counter-width helper.
package out_port_serial_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      STOP     = 3'd3,
      ACK_WAIT = 3'd4
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Bits needed to count 0..n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/out_port_serial_if.sv
// Bus-side and device-side signals of the output port. The CPU/bench side
// (master) drives WBUS, nLo and ACKNOWLEDGE; the port (slave) drives the rest.
interface out_port_serial_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] WBUS;
   logic             nLo;
   logic             ACKNOWLEDGE;
   logic [WIDTH-1:0] PORT_OUT;
   logic             SERIAL_OUT;
   logic             READY;
   logic             OVERRUN;

   modport master (
      output WBUS, nLo, ACKNOWLEDGE,
      input  PORT_OUT, SERIAL_OUT, READY, OVERRUN
   );

   modport slave (
      input  WBUS, nLo, ACKNOWLEDGE,
      output PORT_OUT, SERIAL_OUT, READY, OVERRUN
   );
endinterface

// File: rtl/out_port_serial_bit_timer.sv
// Bit-period timer: counts CLK cycles within one serial bit and flags the
// last cycle of each period. clr holds the count at zero.
module bit_timer
   import out_port_serial_pkg::*;
#(
   parameter int BIT_CYCLES = 4
) (
   input  logic CLK,
   input  logic nCLR,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = cnt_width(BIT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   // Cycle counter: restarts at each bit boundary or when cleared.
   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         cnt_q <= '0;
      end else if (clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/out_port_serial.sv
// SAP-II output port. Reads a word from WBUS on a low nLo, shows it on
// PORT_OUT and sends it as a start/8-data/stop serial frame, then waits for
// the external device to acknowledge before accepting the next word.
module out_port_serial
   import out_port_serial_pkg::*;
#(
   parameter int BIT_CYCLES = 4,
   parameter int WIDTH      = 8
) (
   input logic               CLK,
   input logic               nCLR,
   out_port_serial_if.slave  bus
);

   localparam int            BW       = cnt_width(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0] port_q, port_d;
   logic             serial_q, serial_d;
   logic             ready_q, ready_d;
   logic             overrun_q, overrun_d;
   logic             load;
   logic             tick;
   logic             timer_clr;

   assign load = !bus.nLo;

   // The timer only runs inside a bit-timed state and restarts on every
   // state change so each state begins with a full bit period.
   assign timer_clr = (state_d != state_q) || (state_q == IDLE) ||
                      (state_q == ACK_WAIT);

   bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .CLK  (CLK),
      .nCLR (nCLR),
      .clr  (timer_clr),
      .tick (tick)
   );

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that every port output comes straight from a flop.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      port_d    = port_q;
      serial_d  = serial_q;
      overrun_d = load && !ready_q;

      case (state_q)
         IDLE: begin
            serial_d = LINE_IDLE;
            if (load) begin
               state_d  = START;
               shreg_d  = bus.WBUS;
               port_d   = bus.WBUS;
               serial_d = START_BIT;
            end
         end
         START: begin
            if (tick) begin
               state_d  = DATA;
               serial_d = shreg_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (bitcnt_q == LAST_BIT) begin
                  state_d  = STOP;
                  serial_d = STOP_BIT;
               end else begin
                  bitcnt_d = bitcnt_q + BW'(1);
                  serial_d = shreg_q[1];
               end
            end
         end
         STOP: begin
            serial_d = STOP_BIT;
            if (tick) begin
               state_d  = ACK_WAIT;
               serial_d = LINE_IDLE;
            end
         end
         ACK_WAIT: begin
            serial_d = LINE_IDLE;
            if (bus.ACKNOWLEDGE) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            serial_d = LINE_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         bitcnt_d = '0;
      end
      ready_d = (state_d == IDLE);
   end

   // State, datapath and output registers; reset aborts any frame at once.
   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
         port_q    <= '0;
         serial_q  <= LINE_IDLE;
         ready_q   <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         port_q    <= port_d;
         serial_q  <= serial_d;
         ready_q   <= ready_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.PORT_OUT   = port_q;
   assign bus.SERIAL_OUT = serial_q;
   assign bus.READY      = ready_q;
   assign bus.OVERRUN    = overrun_q;

endmodule

// File: tb/tb_out_port_serial.sv
// Bench for out_port_serial: two instances (BIT_CYCLES=4 and 1) checked every
// cycle against a frame-level reference model, plus directed literal checks.
module tb_out_port_serial;

   localparam int BC [2] = '{4, 1};

   logic CLK  = 1'b0;
   logic nCLR = 1'b1;

   logic       nlo  [2];
   logic [7:0] wbus [2];
   logic       ack  [2];

   logic       ser_o  [2];
   logic       rdy_o  [2];
   logic       ov_o   [2];
   logic [7:0] port_o [2];

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   out_port_serial_if #(.WIDTH(8)) if0 ();
   out_port_serial_if #(.WIDTH(8)) if1 ();

   assign if0.nLo = nlo[0];
   assign if0.WBUS = wbus[0];
   assign if0.ACKNOWLEDGE = ack[0];
   assign if1.nLo = nlo[1];
   assign if1.WBUS = wbus[1];
   assign if1.ACKNOWLEDGE = ack[1];

   assign ser_o[0]  = if0.SERIAL_OUT;
   assign rdy_o[0]  = if0.READY;
   assign ov_o[0]   = if0.OVERRUN;
   assign port_o[0] = if0.PORT_OUT;
   assign ser_o[1]  = if1.SERIAL_OUT;
   assign rdy_o[1]  = if1.READY;
   assign ov_o[1]   = if1.OVERRUN;
   assign port_o[1] = if1.PORT_OUT;

   out_port_serial #(.BIT_CYCLES(4), .WIDTH(8)) dut4 (
      .CLK  (CLK),
      .nCLR (nCLR),
      .bus  (if0)
   );

   out_port_serial #(.BIT_CYCLES(1), .WIDTH(8)) dut1 (
      .CLK  (CLK),
      .nCLR (nCLR),
      .bus  (if1)
   );

   always #5 CLK = ~CLK;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: a frame is a 10-bit vector {stop, data, start} played
   // out B cycles per bit, followed by an acknowledge wait.
   logic       m_rdy   [2];
   logic       m_ser   [2];
   logic       m_ov    [2];
   logic       m_act   [2];
   logic       m_ackw  [2];
   logic [7:0] m_port  [2];
   logic [9:0] m_frame [2];
   int         m_pos   [2];

   always @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         for (int i = 0; i < 2; i++) begin
            m_rdy[i]   <= 1'b1;
            m_ser[i]   <= 1'b1;
            m_ov[i]    <= 1'b0;
            m_act[i]   <= 1'b0;
            m_ackw[i]  <= 1'b0;
            m_port[i]  <= 8'h00;
            m_frame[i] <= 10'h3FF;
            m_pos[i]   <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_ov[i] <= !nlo[i] && !m_rdy[i];
            if (m_rdy[i] && !nlo[i]) begin
               m_port[i]  <= wbus[i];
               m_frame[i] <= {1'b1, wbus[i], 1'b0};
               m_pos[i]   <= 0;
               m_ser[i]   <= 1'b0;
               m_rdy[i]   <= 1'b0;
               m_act[i]   <= 1'b1;
            end else if (m_act[i]) begin
               if (m_pos[i] + 1 < 10 * BC[i]) begin
                  m_pos[i] <= m_pos[i] + 1;
                  m_ser[i] <= m_frame[i][(m_pos[i] + 1) / BC[i]];
               end else begin
                  m_act[i]  <= 1'b0;
                  m_ackw[i] <= 1'b1;
                  m_ser[i]  <= 1'b1;
               end
            end else if (m_ackw[i]) begin
               m_ser[i] <= 1'b1;
               if (ack[i]) begin
                  m_ackw[i] <= 1'b0;
                  m_rdy[i]  <= 1'b1;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the model.
   always @(negedge CLK) begin
      if (cmp_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("inst%0d SERIAL_OUT", i), 32'(ser_o[i]), 32'(m_ser[i]));
            chk($sformatf("inst%0d READY", i), 32'(rdy_o[i]), 32'(m_rdy[i]));
            chk($sformatf("inst%0d OVERRUN", i), 32'(ov_o[i]), 32'(m_ov[i]));
            chk($sformatf("inst%0d PORT_OUT", i), 32'(port_o[i]), 32'(m_port[i]));
         end
      end
   end

   task automatic wait_ready(input int i);
      int n = 0;
      while (rdy_o[i] !== 1'b1 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk($sformatf("inst%0d wait READY", i), 32'(rdy_o[i]), 32'd1);
   endtask

   // Load d on instance i and check the frame against a literal bit pattern
   // (bit k = k-th transmitted bit). ov_k >= 0 injects a rejected load.
   task automatic run_frame(input int i, input logic [7:0] d,
                            input logic [9:0] pat, input int ov_k);
      int b = BC[i];
      wait_ready(i);
      nlo[i]  = 1'b0;
      wbus[i] = d;
      @(negedge CLK);
      nlo[i]  = 1'b1;
      wbus[i] = 8'hxx;
      for (int k = 0; k < 10 * b; k++) begin
         chk($sformatf("inst%0d frame bit k=%0d", i, k), 32'(ser_o[i]), 32'(pat[k / b]));
         chk($sformatf("inst%0d model bit k=%0d", i, k), 32'(m_ser[i]), 32'(pat[k / b]));
         chk($sformatf("inst%0d PORT_OUT k=%0d", i, k), 32'(port_o[i]), 32'(d));
         chk($sformatf("inst%0d READY busy k=%0d", i, k), 32'(rdy_o[i]), 32'd0);
         if (k == ov_k) begin
            nlo[i]  = 1'b0;
            wbus[i] = 8'h3C;
         end else if (ov_k >= 0 && k == ov_k + 1) begin
            nlo[i]  = 1'b1;
            wbus[i] = 8'hxx;
            chk($sformatf("inst%0d OVERRUN pulse", i), 32'(ov_o[i]), 32'd1);
         end else if (ov_k >= 0 && k == ov_k + 2) begin
            chk($sformatf("inst%0d OVERRUN end", i), 32'(ov_o[i]), 32'd0);
         end
         @(negedge CLK);
      end
      chk($sformatf("inst%0d READY in ack wait", i), 32'(rdy_o[i]), 32'd0);
      chk($sformatf("inst%0d line idle after stop", i), 32'(ser_o[i]), 32'd1);
      @(negedge CLK);
      chk($sformatf("inst%0d READY after 10B+1", i), 32'(rdy_o[i]), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         nlo[i]  = 1'b1;
         wbus[i] = 8'h00;
         ack[i]  = 1'b1;
      end
      #1 nCLR = 1'b0;
      #2;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("inst%0d reset SERIAL_OUT", i), 32'(ser_o[i]), 32'd1);
         chk($sformatf("inst%0d reset READY", i), 32'(rdy_o[i]), 32'd1);
         chk($sformatf("inst%0d reset PORT_OUT", i), 32'(port_o[i]), 32'h00);
         chk($sformatf("inst%0d reset OVERRUN", i), 32'(ov_o[i]), 32'd0);
      end
      cmp_en = 1'b1;
      #20 nCLR = 1'b1;
      @(negedge CLK);
      wbus[0] = 8'hxx;
      wbus[1] = 8'hxx;
      repeat (3) @(negedge CLK);

      // A5 frame, then the same frame with a rejected load of 3C mid-frame.
      run_frame(0, 8'hA5, 10'b1101001010, -1);
      run_frame(0, 8'hA5, 10'b1101001010, 10);

      // Acknowledge withheld: port stays busy with the line idle.
      wait_ready(0);
      ack[0]  = 1'b0;
      nlo[0]  = 1'b0;
      wbus[0] = 8'hA5;
      @(negedge CLK);
      nlo[0]  = 1'b1;
      wbus[0] = 8'hxx;
      for (int k = 0; k < 60; k++) begin
         if (k >= 40) begin
            chk("stall READY", 32'(rdy_o[0]), 32'd0);
            chk("stall SERIAL_OUT", 32'(ser_o[0]), 32'd1);
         end
         if (k == 59) begin
            ack[0]  = 1'b1;
            nlo[0]  = 1'b0;
            wbus[0] = 8'h3C;
         end
         @(negedge CLK);
      end
      nlo[0]  = 1'b1;
      wbus[0] = 8'hxx;
      chk("ack release READY", 32'(rdy_o[0]), 32'd1);
      chk("ack-exit load OVERRUN", 32'(ov_o[0]), 32'd1);
      chk("ack-exit load PORT_OUT", 32'(port_o[0]), 32'hA5);
      @(negedge CLK);
      chk("ack-exit OVERRUN end", 32'(ov_o[0]), 32'd0);

      // Reset in the middle of a frame, then a clean frame of 01.
      wait_ready(0);
      nlo[0]  = 1'b0;
      wbus[0] = 8'hA5;
      @(negedge CLK);
      nlo[0]  = 1'b1;
      wbus[0] = 8'hxx;
      repeat (20) @(negedge CLK);
      #2 nCLR = 1'b0;
      #1;
      chk("midframe reset SERIAL_OUT", 32'(ser_o[0]), 32'd1);
      chk("midframe reset READY", 32'(rdy_o[0]), 32'd1);
      chk("midframe reset PORT_OUT", 32'(port_o[0]), 32'h00);
      chk("midframe reset OVERRUN", 32'(ov_o[0]), 32'd0);
      @(negedge CLK);
      nCLR = 1'b1;
      run_frame(0, 8'h01, 10'b1000000010, -1);

      // One cycle per bit, back-to-back frames.
      run_frame(1, 8'hFF, 10'b1111111110, -1);
      run_frame(1, 8'h00, 10'b1000000000, -1);

      // Randomised traffic on both instances, with one asynchronous reset.
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         if (c == 1500) begin
            #3 nCLR = 1'b0;
            @(negedge CLK);
            nCLR = 1'b1;
         end
         for (int i = 0; i < 2; i++) begin
            nlo[i] = ($urandom_range(0, 5) != 0);
            if (nlo[i] && $urandom_range(0, 3) == 0) wbus[i] = 8'hxx;
            else wbus[i] = 8'($urandom);
            ack[i] = ($urandom_range(0, 3) != 0);
         end
      end
      @(negedge CLK);
      cmp_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
